// File: rtl/ecc_scalar_unblinding.sv
// rtl/ecc_scalar_unblinding.sv - bit-serial restoring reduction of a blinded scalar k' into k' mod n and floor(k'/n)
module ecc_scalar_unblinding #(
   parameter int                    REG_SIZE    = 384,
   parameter int                    RND_SIZE    = 192,
   parameter logic [REG_SIZE-1:0]   GROUP_ORDER = 384'hffffffffffffffffffffffffffffffffffffffffffffffffc7634d81f4372ddf581a0db248b0a77aecec196accc52973
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         zeroize,
   input  logic                         en_i,
   input  logic [REG_SIZE+RND_SIZE-1:0] data_i,
   output logic [REG_SIZE-1:0]          data_o,
   output logic [RND_SIZE-1:0]          rnd_o,
   output logic                         overflow_o,
   output logic                         busy_o
);

   localparam int             W        = REG_SIZE + RND_SIZE;
   localparam int             CW       = $clog2(W + 1);
   localparam logic [CW-1:0]  CNT_INIT = CW'(W);

   typedef enum logic {IDLE, RUN} state_t;

   logic [W-1:0]        in_sh;
   logic [REG_SIZE-1:0] r_reg;
   logic [RND_SIZE-1:0] q_reg;
   logic                ovf_reg;
   logic [CW-1:0]       cnt;

   state_t              state;
   logic [REG_SIZE:0]   t;
   logic [REG_SIZE-1:0] d_low;
   logic                borrow;
   logic                qb;

   // t >= n either because t has its top bit set (n < 2^REG_SIZE) or the low part alone clears n.
   always_comb begin
      state           = (cnt != '0) ? RUN : IDLE;
      t               = {r_reg, in_sh[W-1]};
      {borrow, d_low} = {1'b0, t[REG_SIZE-1:0]} - {1'b0, GROUP_ORDER};
      qb              = t[REG_SIZE] | ~borrow;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_sh   <= '0;
         r_reg   <= '0;
         q_reg   <= '0;
         ovf_reg <= 1'b0;
         cnt     <= '0;
      end else if (zeroize) begin
         in_sh   <= '0;
         r_reg   <= '0;
         q_reg   <= '0;
         ovf_reg <= 1'b0;
         cnt     <= '0;
      end else if (en_i) begin
         in_sh   <= data_i;
         r_reg   <= '0;
         q_reg   <= '0;
         ovf_reg <= 1'b0;
         cnt     <= CNT_INIT;
      end else if (state == RUN) begin
         in_sh   <= in_sh << 1;
         r_reg   <= qb ? d_low : t[REG_SIZE-1:0];
         q_reg   <= {q_reg[RND_SIZE-2:0], qb};
         ovf_reg <= ovf_reg | q_reg[RND_SIZE-1];
         cnt     <= cnt - CW'(1);
      end
   end

   assign data_o     = r_reg;
   assign rnd_o      = q_reg;
   assign overflow_o = ovf_reg;
   assign busy_o     = (state == RUN);

endmodule

// File: tb/tb_ecc_scalar_unblinding.sv
// tb/tb_ecc_scalar_unblinding.sv - randomized bench for ecc_scalar_unblinding against a wide-division reference
module tb_ecc_scalar_unblinding;

   localparam int REG_SIZE = 384;
   localparam int RND_SIZE = 192;
   localparam int W        = REG_SIZE + RND_SIZE;
   localparam logic [REG_SIZE-1:0] N = 384'hffffffffffffffffffffffffffffffffffffffffffffffffc7634d81f4372ddf581a0db248b0a77aecec196accc52973;
   localparam logic [W-1:0] NW = {{RND_SIZE{1'b0}}, N};

   logic                clk;
   logic                reset_n;
   logic                zeroize;
   logic                en_i;
   logic [W-1:0]        data_i;
   logic [REG_SIZE-1:0] data_o;
   logic [RND_SIZE-1:0] rnd_o;
   logic                overflow_o;
   logic                busy_o;

   int n_cmp;
   int n_bad;

   ecc_scalar_unblinding #(.REG_SIZE(REG_SIZE), .RND_SIZE(RND_SIZE), .GROUP_ORDER(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .zeroize    (zeroize),
      .en_i       (en_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .rnd_o      (rnd_o),
      .overflow_o (overflow_o),
      .busy_o     (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain wide division of k' by n.
   task automatic model(input logic [W-1:0] x, output logic [REG_SIZE-1:0] r,
                        output logic [RND_SIZE-1:0] q, output logic ovf);
      logic [W-1:0] qq;
      logic [W-1:0] rr;
      qq  = x / NW;
      rr  = x % NW;
      r   = rr[REG_SIZE-1:0];
      q   = qq[RND_SIZE-1:0];
      ovf = (qq >> RND_SIZE) != '0;
   endtask

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic start_op(input logic [W-1:0] x);
      en_i   = 1'b1;
      data_i = x;
      @(posedge clk);
      #1;
      en_i   = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] x, output int cycles);
      start_op(x);
      cycles = 0;
      while (busy_o && cycles < 1000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic check_vec(input string name, input logic [W-1:0] x, input int cycles);
      logic [REG_SIZE-1:0] er;
      logic [RND_SIZE-1:0] eq;
      logic                eo;
      model(x, er, eq, eo);
      n_cmp++;
      if (cycles !== W) begin
         n_bad++;
         $display("FAIL %s latency: got %0d expected %0d", name, cycles, W);
      end
      n_cmp++;
      if (data_o !== er) begin
         n_bad++;
         $display("FAIL %s data_o: got %h expected %h", name, data_o, er);
      end
      n_cmp++;
      if (rnd_o !== eq) begin
         n_bad++;
         $display("FAIL %s rnd_o: got %h expected %h", name, rnd_o, eq);
      end
      n_cmp++;
      if (overflow_o !== eo) begin
         n_bad++;
         $display("FAIL %s overflow_o: got %b expected %b", name, overflow_o, eo);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      n_cmp++;
      if ({data_o, rnd_o, overflow_o, busy_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got %h/%h/%b/%b expected all zero", data_o, rnd_o, overflow_o, busy_o);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({data_o, rnd_o, overflow_o, busy_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_idle: got %h/%h/%b/%b expected all zero", data_o, rnd_o, overflow_o, busy_o);
      end
   endtask

   task automatic test_basic();
      int           c;
      logic [W-1:0] x;
      x = NW + 1;
      run_op(x, c);
      n_cmp++;
      if (c !== W || data_o !== 384'd1 || rnd_o !== 192'd1 || overflow_o !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_1_plus_n: got cyc=%0d d=%h r=%h o=%b expected cyc=%0d d=1 r=1 o=0",
                  c, data_o, rnd_o, overflow_o, W);
      end
      check_vec("basic_1_plus_n", x, c);
   endtask

   task automatic test_boundaries();
      int           c;
      logic [W-1:0] x;
      run_op('0, c);
      check_vec("zero", '0, c);
      x = (NW - 1) + ({{(W-RND_SIZE){1'b0}}, {RND_SIZE{1'b1}}} * NW);
      run_op(x, c);
      n_cmp++;
      if (data_o !== N - 1 || rnd_o !== {RND_SIZE{1'b1}} || overflow_o !== 1'b0) begin
         n_bad++;
         $display("FAIL max_legal: got d=%h r=%h o=%b expected d=%h r=all-ones o=0",
                  data_o, rnd_o, overflow_o, N - 1);
      end
      check_vec("max_legal", x, c);
      run_op(NW, c);
      n_cmp++;
      if (data_o !== '0 || rnd_o !== 192'd1 || overflow_o !== 1'b0) begin
         n_bad++;
         $display("FAIL exact_n: got d=%h r=%h o=%b expected d=0 r=1 o=0", data_o, rnd_o, overflow_o);
      end
      x = '1;
      run_op(x, c);
      n_cmp++;
      if (overflow_o !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow_flag: got %b expected 1", overflow_o);
      end
      check_vec("all_ones", x, c);
   endtask

   task automatic test_restart();
      int           c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = rand_wide();
      b = rand_wide();
      start_op(a);
      repeat (199) @(posedge clk);
      #1;
      run_op(b, c);
      check_vec("restart_b", b, c);
   endtask

   task automatic test_en_held();
      int           c;
      logic [W-1:0] x;
      en_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         x      = rand_wide();
         data_i = x;
         @(posedge clk);
         #1;
         n_cmp++;
         if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL en_held_busy[%0d]: got %b expected 1", i, busy_o);
         end
      end
      en_i = 1'b0;
      c = 0;
      while (busy_o && c < 1000) begin
         @(posedge clk);
         #1;
         c++;
      end
      check_vec("en_held_last", x, c);
   endtask

   task automatic test_zeroize();
      start_op(rand_wide());
      repeat (299) @(posedge clk);
      #1;
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL zeroize_pre_busy: got %b expected 1", busy_o);
      end
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      n_cmp++;
      if ({data_o, rnd_o, overflow_o, busy_o} !== '0) begin
         n_bad++;
         $display("FAIL zeroize_mid: got %h/%h/%b/%b expected all zero", data_o, rnd_o, overflow_o, busy_o);
      end
   endtask

   task automatic test_zeroize_vs_en();
      int c;
      run_op('1, c);
      zeroize = 1'b1;
      en_i    = 1'b1;
      data_i  = rand_wide();
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      en_i    = 1'b0;
      n_cmp++;
      if ({data_o, rnd_o, overflow_o, busy_o} !== '0) begin
         n_bad++;
         $display("FAIL zeroize_vs_en: got %h/%h/%b/%b expected all zero", data_o, rnd_o, overflow_o, busy_o);
      end
   endtask

   // Blind random (k, rnd) pairs in the bench, then expect the DUT to undo it exactly.
   task automatic test_roundtrip(input int nvec);
      int                  c;
      logic [W-1:0]        tmp;
      logic [REG_SIZE-1:0] k;
      logic [RND_SIZE-1:0] rnd;
      logic [W-1:0]        x;
      for (int i = 0; i < nvec; i++) begin
         tmp = rand_wide();
         k   = tmp[REG_SIZE-1:0];
         if (k >= N) k = k - N;
         rnd = tmp[W-1:REG_SIZE];
         x   = {{RND_SIZE{1'b0}}, k} + ({{REG_SIZE{1'b0}}, rnd} * NW);
         run_op(x, c);
         n_cmp++;
         if (c !== W || data_o !== k || rnd_o !== rnd || overflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL roundtrip[%0d]: got cyc=%0d k=%h rnd=%h o=%b expected k=%h rnd=%h o=0",
                     i, c, data_o, rnd_o, overflow_o, k, rnd);
         end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      zeroize = 1'b0;
      en_i    = 1'b0;
      data_i  = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_restart();
      test_en_held();
      test_zeroize();
      test_zeroize_vs_en();
      test_roundtrip(40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
